// File: rtl/simt_divergence_ctrl_pkg.sv
// Shared types and sizes for the per-warp SIMT divergence controller.
package simt_divergence_ctrl_pkg;

    localparam int WARP_SIZE        = 32;
    localparam int SIMT_STACK_DEPTH = 32;
    localparam int DATA_WIDTH       = 32;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] reconvergence_pc;
        logic [DATA_WIDTH-1:0] next_pc;
        logic [WARP_SIZE-1:0]  thread_mask;
    } simt_stack_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_RC = 2'd1,
        PUSH_NT = 2'd2,
        POP     = 2'd3
    } simt_div_state_e;

endpackage

// File: rtl/simt_divergence_ctrl_stack.sv
// Reconvergence stack: one push or pop per cycle, flush forces it empty.
module simt_divergence_ctrl_stack
    import simt_divergence_ctrl_pkg::*;
#(
    parameter int DEPTH = SIMT_STACK_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  simt_stack_entry_t       push_entry,
    output simt_stack_entry_t       top,
    output logic [$clog2(DEPTH):0]  depth
);
    localparam int AW = $clog2(DEPTH);

    simt_stack_entry_t r_mem [DEPTH];
    logic [AW:0]       r_sp;
    logic [AW-1:0]     w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    // Full pushes and empty pops are dropped so sp never wraps.
    assign w_do_push = push && (r_sp != (AW+1)'(DEPTH));
    assign w_do_pop  = pop && (r_sp != '0);
    assign w_top_idx = AW'(r_sp - 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end else if (w_do_pop) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && w_do_push) begin
            r_mem[r_sp[AW-1:0]] <= push_entry;
        end
    end

    assign top   = (r_sp != '0) ? r_mem[w_top_idx] : '0;
    assign depth = r_sp;

endmodule

// File: rtl/simt_divergence_ctrl.sv
// Per-warp divergence controller: sequences the reconvergence stack, owns the
// active thread mask and issues registered PC redirects to fetch.
module simt_divergence_ctrl
    import simt_divergence_ctrl_pkg::*;
#(
    parameter int WARP_SIZE  = simt_divergence_ctrl_pkg::WARP_SIZE,
    parameter int DEPTH      = SIMT_STACK_DEPTH,
    parameter int DATA_WIDTH = simt_divergence_ctrl_pkg::DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_valid,
    input  logic [DATA_WIDTH-1:0]     init_pc,
    input  logic [WARP_SIZE-1:0]      init_mask,
    input  logic                      br_valid,
    output logic                      br_ready,
    input  logic [WARP_SIZE-1:0]      br_taken_mask,
    input  logic [DATA_WIDTH-1:0]     br_target_pc,
    input  logic [DATA_WIDTH-1:0]     br_fallthrough_pc,
    input  logic [DATA_WIDTH-1:0]     br_reconv_pc,
    input  logic                      issue_valid,
    input  logic [DATA_WIDTH-1:0]     issue_pc,
    output logic [WARP_SIZE-1:0]      active_mask,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    stack_depth,
    output logic                      overflow_err
);
    localparam int DW = $clog2(DEPTH) + 1;

    simt_div_state_e       r_state;
    simt_div_state_e       w_next_state;
    logic [WARP_SIZE-1:0]  r_active_mask;
    logic [WARP_SIZE-1:0]  r_br_t;
    logic [WARP_SIZE-1:0]  r_br_n;
    logic [DATA_WIDTH-1:0] r_br_tgt;
    logic [DATA_WIDTH-1:0] r_br_ft;
    logic [DATA_WIDTH-1:0] r_br_rpc;
    logic [DATA_WIDTH-1:0] r_redirect_pc;
    logic                  r_redirect_valid;
    logic                  r_overflow_err;

    simt_stack_entry_t     w_top;
    simt_stack_entry_t     w_push_entry;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rst_n;
    logic [DW-1:0]         w_depth;
    logic [WARP_SIZE-1:0]  w_t;
    logic [WARP_SIZE-1:0]  w_n;
    logic                  w_diverge;
    logic                  w_ovf_guard;
    logic                  w_at_reconv;
    logic                  w_br_fire;

    assign w_rst_n     = ~rst;
    assign w_t         = br_taken_mask & r_active_mask;
    assign w_n         = r_active_mask & ~br_taken_mask;
    assign w_diverge   = (w_t != '0) && (w_n != '0);
    assign w_ovf_guard = w_depth > DW'(DEPTH - 2);
    assign w_at_reconv = issue_valid && (w_depth != '0) &&
                         (issue_pc == w_top.reconvergence_pc);
    // Branch handshake: a branch transfers on the cycle br_valid && br_ready;
    // br_valid may rise at any time and its fields must hold until that cycle.
    assign w_br_fire   = br_valid && br_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (init_valid) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_at_reconv) begin
                        w_next_state = POP;
                    end else if (w_br_fire && w_diverge && !w_ovf_guard) begin
                        w_next_state = PUSH_RC;
                    end
                end
                PUSH_RC: w_next_state = PUSH_NT;
                PUSH_NT: w_next_state = IDLE;
                POP:     w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        br_ready     = 1'b0;
        busy         = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_push_entry = '0;
        case (r_state)
            IDLE: br_ready = !init_valid && !w_at_reconv;
            PUSH_RC: begin
                busy                          = 1'b1;
                w_push                        = !init_valid;
                w_push_entry.reconvergence_pc = r_br_rpc;
                w_push_entry.next_pc          = r_br_rpc;
                w_push_entry.thread_mask      = r_active_mask;
            end
            PUSH_NT: begin
                busy                          = 1'b1;
                w_push                        = !init_valid;
                w_push_entry.reconvergence_pc = r_br_rpc;
                w_push_entry.next_pc          = r_br_ft;
                w_push_entry.thread_mask      = r_br_n;
            end
            POP: begin
                busy  = 1'b1;
                w_pop = !init_valid;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_mask    <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_overflow_err   <= 1'b0;
            r_br_t           <= '0;
            r_br_n           <= '0;
            r_br_tgt         <= '0;
            r_br_ft          <= '0;
            r_br_rpc         <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            if (init_valid) begin
                r_active_mask    <= init_mask;
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= init_pc;
                r_overflow_err   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // A divergent branch with no room is dropped like an all-not-taken one.
                        if (w_br_fire && w_diverge && w_ovf_guard) begin
                            r_overflow_err <= 1'b1;
                        end else if (w_br_fire && w_diverge) begin
                            r_br_t   <= w_t;
                            r_br_n   <= w_n;
                            r_br_tgt <= br_target_pc;
                            r_br_ft  <= br_fallthrough_pc;
                            r_br_rpc <= br_reconv_pc;
                        end else if (w_br_fire && (w_t != '0)) begin
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= br_target_pc;
                        end
                    end
                    PUSH_NT: begin
                        r_active_mask    <= r_br_t;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_br_tgt;
                    end
                    POP: begin
                        r_active_mask    <= w_top.thread_mask;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_top.next_pc;
                    end
                    default: r_redirect_valid <= 1'b0;
                endcase
            end
        end
    end

    simt_divergence_ctrl_stack #(
        .DEPTH(DEPTH)
    ) u_stack (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .flush      (init_valid),
        .push       (w_push),
        .pop        (w_pop),
        .push_entry (w_push_entry),
        .top        (w_top),
        .depth      (w_depth)
    );

    assign active_mask    = r_active_mask;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign stack_depth    = w_depth;
    assign overflow_err   = r_overflow_err;

endmodule

// File: tb/tb_simt_divergence_ctrl.sv
// Directed bench for simt_divergence_ctrl: redirects checked by a queue-based monitor.
module tb_simt_divergence_ctrl;
    import simt_divergence_ctrl_pkg::*;

    localparam int W  = DATA_WIDTH + WARP_SIZE;
    localparam int DW = $clog2(SIMT_STACK_DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  init_valid;
    logic [DATA_WIDTH-1:0] init_pc;
    logic [WARP_SIZE-1:0]  init_mask;
    logic                  br_valid;
    logic                  br_ready;
    logic [WARP_SIZE-1:0]  br_taken_mask;
    logic [DATA_WIDTH-1:0] br_target_pc;
    logic [DATA_WIDTH-1:0] br_fallthrough_pc;
    logic [DATA_WIDTH-1:0] br_reconv_pc;
    logic                  issue_valid;
    logic [DATA_WIDTH-1:0] issue_pc;
    logic [WARP_SIZE-1:0]  active_mask;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  busy;
    logic [DW-1:0]         stack_depth;
    logic                  overflow_err;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    simt_divergence_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .init_valid        (init_valid),
        .init_pc           (init_pc),
        .init_mask         (init_mask),
        .br_valid          (br_valid),
        .br_ready          (br_ready),
        .br_taken_mask     (br_taken_mask),
        .br_target_pc      (br_target_pc),
        .br_fallthrough_pc (br_fallthrough_pc),
        .br_reconv_pc      (br_reconv_pc),
        .issue_valid       (issue_valid),
        .issue_pc          (issue_pc),
        .active_mask       (active_mask),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .busy              (busy),
        .stack_depth       (stack_depth),
        .overflow_err      (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: every redirect pulse must match the oldest expected {pc, mask}.
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (!rst && redirect_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL redirect_unexpected got pc=%h mask=%h", redirect_pc, active_mask);
            end else begin
                exp = exp_q.pop_front();
                if ({redirect_pc, active_mask} !== exp) begin
                    bad++;
                    $display("FAIL redirect got pc=%h mask=%h exp pc=%h mask=%h",
                             redirect_pc, active_mask, exp[W-1:WARP_SIZE], exp[WARP_SIZE-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_init(input logic [31:0] pc, input logic [31:0] mask);
        init_valid = 1'b1;
        init_pc    = pc;
        init_mask  = mask;
        exp_q.push_back({pc, mask});
        tick();
        init_valid = 1'b0;
    endtask

    // Offers a branch and returns just after the accepting edge.
    task automatic do_branch(input logic [31:0] taken, input logic [31:0] tgt,
                             input logic [31:0] ft, input logic [31:0] rpc);
        int n;
        n                 = 0;
        br_valid          = 1'b1;
        br_taken_mask     = taken;
        br_target_pc      = tgt;
        br_fallthrough_pc = ft;
        br_reconv_pc      = rpc;
        #1;
        while (!br_ready && n < 20) begin
            tick();
            n++;
        end
        if (!br_ready) begin
            total++;
            bad++;
            $display("FAIL br_accept_timeout got=0 exp=1");
        end
        tick();
        br_valid = 1'b0;
    endtask

    task automatic do_issue(input logic [31:0] pc);
        issue_valid = 1'b1;
        issue_pc    = pc;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] m;
        logic [31:0] tk;
        rst = 1'b1; init_valid = 1'b0; init_pc = '0; init_mask = '0;
        br_valid = 1'b0; br_taken_mask = '0; br_target_pc = '0;
        br_fallthrough_pc = '0; br_reconv_pc = '0;
        issue_valid = 1'b0; issue_pc = '0;
        tick(); tick();
        chk("rst_mask", active_mask, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_depth", stack_depth, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Launch
        do_init(32'h100, 32'hFFFF_FFFF);
        chk("init_depth", stack_depth, 0);

        // Divergent branch
        br_valid = 1'b1;
        #1;
        chk("div_ready_idle", br_ready, 1);
        exp_q.push_back({32'h200, 32'h0000_FFFF});
        do_branch(32'h0000_FFFF, 32'h200, 32'h104, 32'h300);
        chk("div_busy_rc", busy, 1);
        chk("div_ready_rc", br_ready, 0);
        tick();
        chk("div_depth_nt", stack_depth, 1);
        chk("div_ready_nt", br_ready, 0);
        tick();
        chk("div_depth_done", stack_depth, 2);
        chk("div_busy_done", busy, 0);

        // Reconvergence pops
        issue_valid = 1'b1;
        issue_pc    = 32'h300;
        #1;
        chk("reconv_ready", br_ready, 0);
        exp_q.push_back({32'h104, 32'hFFFF_0000});
        tick();
        issue_valid = 1'b0;
        chk("pop_busy", busy, 1);
        tick();
        chk("pop1_depth", stack_depth, 1);
        exp_q.push_back({32'h300, 32'hFFFF_FFFF});
        do_issue(32'h300);
        tick();
        chk("pop2_depth", stack_depth, 0);

        // Uniform branches
        exp_q.push_back({32'h400, 32'hFFFF_FFFF});
        do_branch(32'hFFFF_FFFF, 32'h400, 32'h404, 32'h408);
        chk("uni_taken_depth", stack_depth, 0);
        do_branch(32'h0, 32'h500, 32'h504, 32'h508);
        tick();
        chk("uni_nt_depth", stack_depth, 0);
        do_init(32'h600, 32'h0000_00FF);
        exp_q.push_back({32'h700, 32'h0000_00FF});
        do_branch(32'hFFFF_00FF, 32'h700, 32'h704, 32'h708);
        chk("outside_taken_depth", stack_depth, 0);
        do_branch(32'hFFFF_FF00, 32'h800, 32'h804, 32'h808);
        tick();
        chk("outside_nt_mask", active_mask, 32'h0000_00FF);
        chk("outside_nt_depth", stack_depth, 0);

        // Nested divergence up to a full stack, then overflow
        do_init(32'h800, 32'hFFFF_FFFF);
        m = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            tk = m & (m - 1);
            exp_q.push_back({32'h1000 + 32'(i * 16), tk});
            do_branch(tk, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 32'h3000 + 32'(i * 16));
            tick(); tick();
            chk("nest_depth", stack_depth, 64'(2 * (i + 1)));
            m = tk;
        end
        chk("nest_mask", active_mask, 32'hFFFF_0000);
        chk("nest_ovf_clear", overflow_err, 0);
        do_branch(m & (m - 1), 32'h4000, 32'h4004, 32'h4008);
        tick();
        chk("ovf_set", overflow_err, 1);
        chk("ovf_depth", stack_depth, 32);
        chk("ovf_busy", busy, 0);
        chk("ovf_mask", active_mask, 32'hFFFF_0000);

        // Init abandons an in-flight push sequence
        do_init(32'h900, 32'hFFFF_FFFF);
        chk("reinit_ovf", overflow_err, 0);
        chk("reinit_depth", stack_depth, 0);
        do_branch(32'h0000_000F, 32'hA00, 32'hA04, 32'hA08);
        tick();
        chk("abandon_busy_nt", busy, 1);
        chk("abandon_depth_nt", stack_depth, 1);
        do_init(32'hB00, 32'h0000_FFFF);
        chk("abandon_busy", busy, 0);
        chk("abandon_depth", stack_depth, 0);
        chk("abandon_ovf", overflow_err, 0);

        // Reset in the middle of a pop
        exp_q.push_back({32'hC00, 32'h0000_00FF});
        do_branch(32'h0000_00FF, 32'hC00, 32'hC04, 32'hD00);
        tick(); tick();
        chk("pre_pop_depth", stack_depth, 2);
        do_issue(32'hD00);
        chk("midpop_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("midpop_rst_mask", active_mask, 0);
        chk("midpop_rst_rv", redirect_valid, 0);
        chk("midpop_rst_pc", redirect_pc, 0);
        chk("midpop_rst_ovf", overflow_err, 0);
        chk("midpop_rst_depth", stack_depth, 0);
        chk("midpop_rst_busy", busy, 0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
